// File: rtl/mem_dump_pkg.sv
`timescale 1ns/1ps
// Shared types and width helpers for the line-memory dump engine.
package mem_dump_pkg;

  typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE} state_t;

  localparam int WORD_W_DEF = 32;
  localparam int LAT_W      = 3;

  function automatic int line_w(input int word_w, input int words_per_line);
    return word_w * words_per_line;
  endfunction

  function automatic int idx_w(input int num_lines, input int words_per_line);
    return $clog2(num_lines) + $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/mem_line_dump_unit_line_word_mux.sv
`timescale 1ns/1ps
// Line buffer loaded once per memory read; word select is combinational, one word per cycle.
module line_word_mux
  import mem_dump_pkg::*;
#(
  parameter int WORD_W         = WORD_W_DEF,
  parameter int WORDS_PER_LINE = 16,
  localparam int LINE_W        = line_w(WORD_W, WORDS_PER_LINE),
  localparam int WP_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [LINE_W-1:0] i_line,
  input  logic [WP_W-1:0]   i_sel,
  output logic [WORD_W-1:0] o_word
);

  logic [WORDS_PER_LINE-1:0][WORD_W-1:0] r_buf;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buf <= '0;
    end else if (i_load) begin
      r_buf <= i_line;
    end
  end

  assign o_word = r_buf[i_sel];

endmodule

// File: rtl/mem_line_dump_unit.sv
`timescale 1ns/1ps
// End-of-program dump: on an END_PC edge, reads lines and streams words FIRST_WORD..LAST_WORD
// over valid/ready (outputs hold while stalled), then raises halt_req. Checksum ports: DUMP_CHECKSUM_EN.
module mem_line_dump_unit
  import mem_dump_pkg::*;
#(
  parameter int              WORD_W         = WORD_W_DEF,
  parameter int              WORDS_PER_LINE = 16,
  parameter int              NUM_LINES      = 64,
  parameter int              PC_W           = 32,
  parameter logic [PC_W-1:0] END_PC         = PC_W'(32'h80),
  parameter int              FIRST_WORD     = 32,
  parameter int              LAST_WORD      = 127,
  parameter int              READ_LAT       = 1,
  localparam int             LINE_W         = line_w(WORD_W, WORDS_PER_LINE),
  localparam int             LA_W           = $clog2(NUM_LINES),
  localparam int             WP_W           = $clog2(WORDS_PER_LINE),
  localparam int             IDX_W          = idx_w(NUM_LINES, WORDS_PER_LINE)
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic [PC_W-1:0]   i_pc,
  output logic              o_line_rd_en,
  output logic [LA_W-1:0]   o_line_addr,
  input  logic [LINE_W-1:0] i_line_rdata,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [WORD_W-1:0] o_dump_word,
  output logic [IDX_W-1:0]  o_dump_idx,
  output logic              o_dump_last,
  output logic              o_busy,
  output logic              o_halt_req
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] o_dump_csum,
  output logic              o_csum_valid
`endif
);

  state_t            r_state;
  state_t            w_next;
  logic              r_pc_hit;
  logic [LA_W-1:0]   r_line;
  logic [WP_W-1:0]   r_word;
  logic [LAT_W-1:0]  r_lat;
  logic              w_trigger;
  logic              w_accept;
  logic              w_is_last;
  logic              w_line_end;
  logic              w_lat_done;
  logic              w_load;
  logic [IDX_W-1:0]  w_flat;
  logic [WORD_W-1:0] w_word;

  assign w_trigger  = (i_pc == END_PC) & ~r_pc_hit;
  assign w_flat     = {r_line, r_word};
  assign w_is_last  = (w_flat == IDX_W'(LAST_WORD));
  assign w_line_end = (r_word == WP_W'(WORDS_PER_LINE - 1));
  assign w_lat_done = (r_lat == LAT_W'(READ_LAT - 1));
  assign w_accept   = (r_state == EMIT) & i_dump_ready;
  assign w_load     = (r_state == WAIT) & w_lat_done;

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_trigger) w_next = READ;
      READ:    w_next = WAIT;
      WAIT:    if (w_lat_done) w_next = EMIT;
      EMIT: begin
        if (w_accept) begin
          if (w_is_last) begin
            w_next = DONE;
          end else if (w_line_end) begin
            w_next = READ;
          end
        end
      end
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_line_rd_en = 1'b0;
    o_line_addr  = '0;
    o_dump_valid = 1'b0;
    o_dump_word  = '0;
    o_dump_idx   = '0;
    o_busy       = 1'b0;
    o_halt_req   = 1'b0;
    case (r_state)
      READ: begin
        o_line_rd_en = 1'b1;
        o_line_addr  = r_line;
        o_busy       = 1'b1;
      end
      WAIT: o_busy = 1'b1;
      EMIT: begin
        o_dump_valid = 1'b1;
        o_dump_word  = w_word;
        o_dump_idx   = w_flat;
        o_busy       = 1'b1;
      end
      DONE: o_halt_req = 1'b1;
      default: ;
    endcase
  end

  assign o_dump_last = o_dump_valid & w_is_last;

  // Edge register tracks pc every cycle so a held END_PC fires only once.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_pc_hit <= 1'b0;
      r_line   <= '0;
      r_word   <= '0;
      r_lat    <= '0;
    end else begin
      r_pc_hit <= (i_pc == END_PC);
      if ((r_state == IDLE) && w_trigger) begin
        r_line <= LA_W'(FIRST_WORD / WORDS_PER_LINE);
        r_word <= WP_W'(FIRST_WORD % WORDS_PER_LINE);
      end
      if (r_state == READ) begin
        r_lat <= '0;
      end else if (r_state == WAIT) begin
        r_lat <= r_lat + LAT_W'(1);
      end
      if (w_accept && !w_is_last) begin
        if (w_line_end) begin
          r_word <= '0;
          r_line <= r_line + LA_W'(1);
        end else begin
          r_word <= r_word + WP_W'(1);
        end
      end
    end
  end

  line_word_mux #(
    .WORD_W        (WORD_W),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_line_word_mux (
    .i_clk (i_clk),
    .i_rst (i_clr),
    .i_load(w_load),
    .i_line(i_line_rdata),
    .i_sel (r_word),
    .o_word(w_word)
  );

`ifdef DUMP_CHECKSUM_EN
  logic [WORD_W-1:0] r_csum;

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_csum <= '0;
    end else if ((r_state == IDLE) && w_trigger) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= r_csum + w_word;
    end
  end

  assign o_dump_csum  = r_csum;
  assign o_csum_valid = (r_state == DONE);
`endif

endmodule
